// File: rtl/prog_modulo_counter.sv
// prog_modulo_counter: up/down counter with a runtime modulus, synchronous load,
// and an optional one-shot mode that parks the counter in HALT after its first wrap.
// Optional feature macro: PROG_MODULO_COUNTER_STEP_EN adds a W-bit step input;
// without it the counter always moves by one.
module prog_modulo_counter #(
    parameter int W    = 8,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod_n,
    input  logic         oneshot,
`ifdef PROG_MODULO_COUNTER_STEP_EN
    input  logic [W-1:0] step,
`endif
    output logic [W-1:0] count,
    output logic         tc,
    output logic         wrap,
    output logic         done
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [W-1:0] INIT_V = W'(INIT);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] mod_eff;
    logic [W-1:0] step_eff;
    logic         step_hold;
    logic [W-1:0] count_nxt;
    logic         step_wraps;
    logic [W:0]   sum_up;
    logic [W:0]   sum_dn;
    logic [W-1:0] load_fit;
    logic [W-1:0] init_fit;

    // Effective modulus: anything below 2 collapses to a modulus of one.
    always_comb begin
        mod_eff = (mod_n < W'(2)) ? W'(1) : mod_n;
    end

`ifdef PROG_MODULO_COUNTER_STEP_EN
    // Clamp the requested step into the modulus; a zero step means "stand still".
    always_comb begin
        step_eff  = (step >= mod_eff) ? mod_eff - W'(1) : step;
        step_hold = (mod_eff != W'(1)) && (step_eff == '0);
    end
`else
    // Fixed unit step when the step input is not built.
    always_comb begin
        step_eff  = W'(1);
        step_hold = 1'b0;
    end
`endif

    // Next count for one enabled step, and whether that step wraps.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        count_nxt  = count;
        step_wraps = 1'b0;
        sum_up     = {1'b0, count} + {1'b0, step_eff};
        sum_dn     = {1'b0, count} + {1'b0, mod_eff} - {1'b0, step_eff};
        if (mod_eff == W'(1)) begin
            // Modulus of one: count pinned at zero, every step is a wrap.
            step_wraps = 1'b1;
            count_nxt  = '0;
        end else if (step_hold) begin
            count_nxt = count;
        end else if (count >= mod_eff) begin
            // Modulus was lowered below the current count: resynchronise.
            step_wraps = 1'b1;
            count_nxt  = up ? '0 : mod_eff - W'(1);
        end else if (up) begin
            if (sum_up >= {1'b0, mod_eff}) begin
                step_wraps = 1'b1;
                count_nxt  = W'(sum_up - {1'b0, mod_eff});
            end else begin
                count_nxt = sum_up[W-1:0];
            end
        end else begin
            if (count < step_eff) begin
                step_wraps = 1'b1;
                count_nxt  = sum_dn[W-1:0];
            end else begin
                count_nxt = count - step_eff;
            end
        end
    end

    // Load and reset values, forced to zero when outside the current modulus.
    always_comb begin
        load_fit = (load_val < mod_eff) ? load_val : '0;
        init_fit = (INIT_V < mod_eff) ? INIT_V : '0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic: a load always restarts, a one-shot wrap halts.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (en && step_wraps && oneshot) state_nxt = HALT;
                HALT:    if (!oneshot) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // FSM outputs: terminal-count flag and halted indication.
    always_comb begin
        tc   = en && (state == RUN) && step_wraps;
        done = (state == HALT);
    end

    // Count register: reset > load > enabled step in RUN; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= init_fit;
        end else if (load) begin
            count <= load_fit;
        end else if (en && (state == RUN)) begin
            count <= count_nxt;
        end
    end

    // Wrap pulse: registered copy of the terminal-count step, cleared by load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_prog_modulo_counter.sv
// Self-checking bench for prog_modulo_counter. A behavioural model predicts each
// cycle's outcome; predictions are queued when inputs are driven and compared
// against the DUT after the clock edge. Build with PROG_MODULO_COUNTER_STEP_EN
// defined to also exercise the step input.
module tb_prog_modulo_counter;

    localparam int W    = 8;
    localparam int INIT = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] mod_n;
    logic         oneshot;
`ifdef PROG_MODULO_COUNTER_STEP_EN
    logic [W-1:0] step;
    int           step_val = 1;
`endif
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         done;

    typedef struct {
        int    count;
        bit    wrap;
        bit    done;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   m_cnt  = 0;
    bit   m_halt = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    prog_modulo_counter #(.W(W), .INIT(INIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_n    (mod_n),
        .oneshot  (oneshot),
`ifdef PROG_MODULO_COUNTER_STEP_EN
        .step     (step),
`endif
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the outcome, then compare after the edge.
    task automatic run_cycle(input string tag, input bit r, input bit ld, input bit e,
                             input bit u, input bit os, input int lv, input int mn);
        int   me;
        int   se;
        int   nxt;
        bit   wr;
        bit   hold;
        exp_t x;
        exp_t y;
        @(negedge clk);
        reset    = r;
        load     = ld;
        en       = e;
        up       = u;
        oneshot  = os;
        load_val = W'(lv);
        mod_n    = W'(mn);
        me = (mn < 2) ? 1 : mn;
`ifdef PROG_MODULO_COUNTER_STEP_EN
        step = W'(step_val);
        se   = (step_val >= me) ? me - 1 : step_val;
`else
        se = 1;
`endif
        hold = (me != 1) && (se == 0);
        wr   = 1'b0;
        nxt  = m_cnt;
        if (me == 1) begin
            wr  = 1'b1;
            nxt = 0;
        end else if (hold) begin
            nxt = m_cnt;
        end else if (m_cnt >= me) begin
            wr  = 1'b1;
            nxt = u ? 0 : me - 1;
        end else if (u) begin
            if (m_cnt + se >= me) begin
                wr  = 1'b1;
                nxt = m_cnt + se - me;
            end else begin
                nxt = m_cnt + se;
            end
        end else begin
            if (m_cnt < se) begin
                wr  = 1'b1;
                nxt = m_cnt + me - se;
            end else begin
                nxt = m_cnt - se;
            end
        end
        #1;
        check($sformatf("%s.tc", tag), {31'd0, tc}, {31'd0, (e && !m_halt && wr)});
        x.wrap = 1'b0;
        if (r) begin
            m_cnt  = (INIT >= me) ? 0 : INIT;
            m_halt = 1'b0;
        end else if (ld) begin
            m_cnt  = (lv < me) ? lv : 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            if (!os) m_halt = 1'b0;
        end else if (e) begin
            m_cnt  = nxt;
            x.wrap = wr;
            if (wr && os) m_halt = 1'b1;
        end
        x.count = m_cnt;
        x.done  = m_halt;
        x.tag   = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check($sformatf("%s.count", y.tag), {24'd0, count}, y.count);
        check($sformatf("%s.wrap", y.tag), {31'd0, wrap}, {31'd0, y.wrap});
        check($sformatf("%s.done", y.tag), {31'd0, done}, {31'd0, y.done});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        run_cycle("rst", 1, 0, 0, 1, 0, 0, 10);
        run_cycle("rst", 1, 0, 0, 1, 0, 0, 10);

        // Count up modulo 10: 0..9,0 then back to 0 again.
        for (int i = 0; i < 10; i++) run_cycle("up10", 0, 0, 1, 1, 0, 0, 10);
        // Count down modulo 10 from 0: 9,8,...,0,9,8.
        for (int i = 0; i < 12; i++) run_cycle("dn10", 0, 0, 1, 0, 0, 0, 10);

        // One-shot with modulus 5: 1..4,0 then halt and hold.
        run_cycle("os_ld0", 0, 1, 0, 1, 1, 0, 5);
        for (int i = 0; i < 7; i++) run_cycle("os_run", 0, 0, 1, 1, 1, 0, 5);
        // Load 3 restarts from HALT.
        run_cycle("os_ld3", 0, 1, 1, 1, 1, 3, 5);
        for (int i = 0; i < 4; i++) run_cycle("os_run2", 0, 0, 1, 1, 1, 0, 5);
        // Clearing oneshot leaves HALT; counting resumes the cycle after.
        for (int i = 0; i < 3; i++) run_cycle("os_exit", 0, 0, 1, 1, 0, 0, 5);

        // Modulus lowered below the current count.
        run_cycle("lo_ld8", 0, 1, 0, 1, 0, 8, 10);
        run_cycle("lo_up", 0, 0, 1, 1, 0, 0, 6);
        run_cycle("lo_ld8b", 0, 1, 0, 1, 0, 8, 10);
        run_cycle("lo_dn", 0, 0, 1, 0, 0, 0, 6);

        // Enable low holds.
        for (int i = 0; i < 3; i++) run_cycle("hold", 0, 0, 0, 1, 0, 0, 10);

        // Reset beats simultaneous load and enable; oversize load lands on 0.
        run_cycle("pre_ld5", 0, 1, 0, 1, 0, 5, 10);
        run_cycle("rle", 1, 1, 1, 1, 0, 7, 10);
        run_cycle("ld12", 0, 1, 0, 1, 0, 12, 10);

        // Modulus of 0 and 1: pinned at 0, wrapping on every enabled step.
        run_cycle("m0_ld", 0, 1, 0, 1, 0, 3, 10);
        for (int i = 0; i < 3; i++) run_cycle("m0", 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle("m1", 0, 0, 1, 0, 0, 0, 1);

        // Reset while halted.
        run_cycle("rh_ld", 0, 1, 0, 1, 1, 0, 3);
        for (int i = 0; i < 4; i++) run_cycle("rh_run", 0, 0, 1, 1, 1, 0, 3);
        run_cycle("rh_rst", 1, 0, 1, 1, 1, 0, 3);
        run_cycle("rh_after", 0, 0, 1, 1, 1, 0, 3);

`ifdef PROG_MODULO_COUNTER_STEP_EN
        // Step of 3 modulo 10: 3,6,9,2.
        step_val = 3;
        run_cycle("st3_ld", 0, 1, 0, 1, 0, 0, 10);
        for (int i = 0; i < 4; i++) run_cycle("st3", 0, 0, 1, 1, 0, 0, 10);
        // Step of 15 clamps to 9.
        step_val = 15;
        run_cycle("st15_ld", 0, 1, 0, 1, 0, 0, 10);
        for (int i = 0; i < 3; i++) run_cycle("st15", 0, 0, 1, 1, 0, 0, 10);
        // Step of 0 holds without wrapping.
        step_val = 0;
        for (int i = 0; i < 2; i++) run_cycle("st0", 0, 0, 1, 1, 0, 0, 10);
        step_val = 1;
`endif

        // Random mix of all controls.
        for (int i = 0; i < 300; i++) begin
`ifdef PROG_MODULO_COUNTER_STEP_EN
            step_val = $urandom_range(0, 15);
`endif
            run_cycle("rand",
                      ($urandom_range(0, 31) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_modulo_counter.md
PROG_MODULO_COUNTER -- requirements
Module: prog_modulo_counter

Interface
REQ-001 SHALL have parameter W, default 8: counter and modulus width in bits (W >= 2).
REQ-002 SHALL have parameter INIT, default 0: count value after reset (must be < 2^W).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; one step per cycle when high.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous load of load_val.
REQ-008 SHALL have port load_val  input  W  value to load.
REQ-009 SHALL have port mod_n  input  W  runtime modulus; mod_eff = (mod_n < 2) ? 1 : mod_n.
REQ-010 SHALL have port oneshot  input  1  1 = halt after the first wrap; 0 = free-running.
REQ-011 SHALL have port count  output  W  current count, registered.
REQ-012 SHALL have port tc  output  1  combinational terminal-count flag: en & RUN & next step wraps.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap.
REQ-014 SHALL have port done  output  1  high while the FSM is in HALT.

Function
REQ-015 SHALL apply priority reset > load > en; with en=0 and load=0, all state holds.
REQ-016 SHALL, on load, set count to load_val if load_val < mod_eff, else to 0; force the FSM to RUN; and drive wrap to 0 next cycle.
REQ-017 SHALL use an FSM with states RUN and HALT: RUN->HALT on an enabled wrap while oneshot=1; HALT->RUN on load, reset, or oneshot=0; no other transitions.
REQ-018 SHALL, in HALT, hold count regardless of en and keep tc=0.
REQ-019 SHALL, when counting up in RUN, wrap when count+step >= mod_eff (computed at W+1 bits) to count+step-mod_eff; otherwise set count to count+step.
REQ-020 SHALL, when counting down in RUN, wrap when count < step to count+mod_eff-step (W+1 bits); otherwise set count to count-step.
REQ-021 SHALL, if count >= mod_eff (modulus lowered at runtime), treat the next enabled step as a wrap to 0 (up) or mod_eff-1 (down).
REQ-022 SHALL, with mod_eff = 1, hold count at 0 and treat every enabled RUN step as a wrap.
REQ-023 SHALL assert wrap exactly one cycle after each wrap step and deassert it in every other cycle.
REQ-024 SHALL allow mod_n, up and oneshot to change in any cycle, taking effect on the same cycle's step.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set count=INIT (0 if INIT >= mod_eff), wrap=0 and FSM=RUN, and hence done=0; tc follows REQ-012.
REQ-026 SHALL let reset override a simultaneous load or en, including mid-count and in HALT.

Configuration
REQ-027 SHALL, with macro PROG_MODULO_COUNTER_STEP_EN defined, add port step (input, W bits): step size, with step >= mod_eff clamped to mod_eff-1 and step = 0 holding count without a wrap.
REQ-028 SHALL, without PROG_MODULO_COUNTER_STEP_EN, have no step port and use a fixed step of 1.

Verification
REQ-029 SHALL cover: W=8, mod_n=10, up=1, en=1 from reset -> count 0..9,0; tc=1 when count=9; wrap=1 in the cycle count returns to 0.
REQ-030 SHALL cover: mod_n=10, up=0, from count=0 -> count 9,8,...; wrap pulses after each 0->9 step.
REQ-031 SHALL cover: oneshot=1, mod_n=5 -> count 0..4,0 then holds at 0 with done=1; load with load_val=3 -> done=0 and counting resumes from 3.
REQ-032 SHALL cover: count=8 while mod_n changes 10->6 -> next up step gives count=0 with wrap pulse; next down step from 8 gives 5.
REQ-033 SHALL cover: reset, load and en all high in one cycle -> count=INIT and done=0; load_val=12 with mod_n=10 -> count=0.
REQ-034 SHALL cover, with STEP_EN: mod_n=10, step=3, up=1 from count 0 -> 3,6,9,2 with wrap after 9->2; step=15 -> behaves as step=9.
